// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants and the display-word type for the 7-segment scan driver
package seg_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SCAN_W = 2;
  localparam int SCAN_DIV_DEF = 50000;
  localparam int BLINK_FRAMES_DEF = 25;
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] hex;
    logic [NUM_DIGITS-1:0] point;
    logic [NUM_DIGITS-1:0] blink;
  } disp_word_t;
endpackage

// File: rtl/seg_tick_div.sv
// seg_tick_div: enabled modulo-MOD counter that pulses tick_o on its terminal count
module seg_tick_div #(
  parameter int MOD = 4,
  localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = en_i && cnt_q == W'(MOD - 1);
    cnt_d = tick_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scan-index divider, frame-synchronous display registers and blink gating
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_hex,
  input  logic [NUM_DIGITS-1:0]   wr_point,
  input  logic [NUM_DIGITS-1:0]   wr_blink,
  output logic [4*NUM_DIGITS-1:0] Hexs,
  output logic [SCAN_W-1:0]       Scan,
  output logic [NUM_DIGITS-1:0]   point,
  output logic [NUM_DIGITS-1:0]   LES,
  output logic                    upd_ack,
  output logic                    pending
);
  logic tick, frame_end, blink_tick, commit;
  logic pending_q, pending_d, phase_q, phase_d, ack_q;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [NUM_DIGITS-1:0] les_q, les_d;
  disp_word_t pend_q, pend_d, live_q, live_d;
  seg_tick_div #(.MOD(SCAN_DIV)) u_div (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1), .tick_o(tick)
  );
  seg_tick_div #(.MOD(BLINK_FRAMES)) u_frame (
    .clk(clk), .rst_n(rst_n), .en_i(frame_end), .tick_o(blink_tick)
  );
  // A commit uses the pending word held before this edge, so a colliding write queues for the next frame
  always_comb begin
    frame_end = tick && scan_q == SCAN_W'(NUM_DIGITS - 1);
    commit = frame_end && pending_q;
    scan_d = tick ? scan_q + 1'b1 : scan_q;
    pend_d = wr_en ? disp_word_t'{hex: wr_hex, point: wr_point, blink: wr_blink} : pend_q;
    pending_d = wr_en || (pending_q && !frame_end);
    live_d = commit ? pend_q : live_q;
    phase_d = phase_q ^ blink_tick;
    les_d = phase_d ? live_d.blink : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
      pending_q <= 1'b0;
      phase_q <= 1'b0;
      ack_q <= 1'b0;
      les_q <= '0;
      pend_q <= '0;
      live_q <= '0;
    end else begin
      scan_q <= scan_d;
      pending_q <= pending_d;
      phase_q <= phase_d;
      ack_q <= commit;
      les_q <= les_d;
      pend_q <= pend_d;
      live_q <= live_d;
    end
  end
  assign Hexs = live_q.hex;
  assign point = live_q.point;
  assign Scan = scan_q;
  assign LES = les_q;
  assign upd_ack = ack_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table-driven output checks plus a commit scoreboard, SCAN_DIV=4, BLINK_FRAMES=2
module tb_seg_scan_driver;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [15:0] wr_hex = '0, Hexs;
  logic [3:0] wr_point = '0, wr_blink = '0, point, LES;
  logic [1:0] Scan;
  logic upd_ack, pending;
  int total = 0, bad = 0;
  typedef struct {int cyc; logic [15:0] hex; logic [3:0] point; logic [3:0] blink;} wr_t;
  typedef struct {int cyc; logic [1:0] scan; logic pend; logic ack; logic [15:0] hex; logic [3:0] point; logic [3:0] les;} chk_t;
  wr_t wq[$];
  chk_t cq[$];
  logic [19:0] sb[$];
  seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_hex(wr_hex), .wr_point(wr_point),
    .wr_blink(wr_blink), .Hexs(Hexs), .Scan(Scan), .point(point), .LES(LES),
    .upd_ack(upd_ack), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic w(input int cyc, input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
    wq.push_back('{cyc, h, p, b});
  endtask
  task automatic c(input int cyc, input logic [1:0] s, input logic pd, input logic a,
                   input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    cq.push_back('{cyc, s, pd, a, h, p, l});
  endtask
  task automatic run(input string name, input int ncyc, input int rst_at);
    int dc;
    bit mp;
    logic [27:0] act, exp;
    logic [19:0] e;
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dc = 0;
    mp = 0;
    sb.delete();
    for (int n = 0; n <= ncyc; n++) begin
      foreach (cq[i]) if (cq[i].cyc == n) begin
        total++;
        act = {Scan, pending, upd_ack, Hexs, point, LES};
        exp = {cq[i].scan, cq[i].pend, cq[i].ack, cq[i].hex, cq[i].point, cq[i].les};
        if (act !== exp) begin
          bad++;
          $display("FAIL %s state@%0d got scan/pend/ack/hex/pt/les=%h_%b_%b_%h_%b_%b want %h_%b_%b_%h_%b_%b",
                   name, n, act[27:26], act[25], act[24], act[23:8], act[7:4], act[3:0],
                   exp[27:26], exp[25], exp[24], exp[23:8], exp[7:4], exp[3:0]);
        end
      end
      if (upd_ack === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected_ack@%0d got hex=%h point=%b want no ack", name, n, Hexs, point);
        end else begin
          e = sb.pop_front();
          if ({Hexs, point} !== e) begin
            bad++;
            $display("FAIL %s commit@%0d got hex=%h point=%b want hex=%h point=%b", name, n, Hexs, point, e[19:4], e[3:0]);
          end
        end
      end
      wr_en = 1'b0;
      rst_n = (n != rst_at);
      foreach (wq[i]) if (wq[i].cyc == n) begin
        wr_en = 1'b1;
        wr_hex = wq[i].hex;
        wr_point = wq[i].point;
        wr_blink = wq[i].blink;
      end
      if (!rst_n) begin
        sb.delete();
        mp = 0;
        dc = 0;
      end else begin
        if (wr_en) begin
          if (mp && dc != 15) void'(sb.pop_back());
          sb.push_back({wr_hex, wr_point});
        end
        mp = wr_en || (mp && dc != 15);
        dc = (dc + 1) % 16;
      end
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s missing_acks got %0d outstanding want 0", name, sb.size());
    end
    wq.delete();
    cq.delete();
  endtask
  initial begin
    c(0, 0, 0, 0, 16'h0, 4'h0, 4'h0); c(3, 0, 0, 0, 16'h0, 4'h0, 4'h0);
    c(4, 1, 0, 0, 16'h0, 4'h0, 4'h0); c(7, 1, 0, 0, 16'h0, 4'h0, 4'h0);
    c(8, 2, 0, 0, 16'h0, 4'h0, 4'h0); c(12, 3, 0, 0, 16'h0, 4'h0, 4'h0);
    c(15, 3, 0, 0, 16'h0, 4'h0, 4'h0); c(16, 0, 0, 0, 16'h0, 4'h0, 4'h0);
    run("divider", 20, -1);
    w(5, 16'h1234, 4'b0010, 4'b0000);
    c(5, 1, 0, 0, 16'h0, 4'h0, 4'h0); c(6, 1, 1, 0, 16'h0, 4'h0, 4'h0);
    c(15, 3, 1, 0, 16'h0, 4'h0, 4'h0); c(16, 0, 0, 1, 16'h1234, 4'b0010, 4'h0);
    c(17, 0, 0, 0, 16'h1234, 4'b0010, 4'h0);
    run("commit", 40, -1);
    w(3, 16'hAAAA, 4'h0, 4'h0); w(9, 16'hBBBB, 4'h0, 4'h0);
    c(10, 2, 1, 0, 16'h0, 4'h0, 4'h0); c(16, 0, 0, 1, 16'hBBBB, 4'h0, 4'h0);
    c(17, 0, 0, 0, 16'hBBBB, 4'h0, 4'h0);
    run("latest_wins", 40, -1);
    w(2, 16'h1111, 4'h0, 4'h0); w(15, 16'h2222, 4'h0, 4'h0);
    c(15, 3, 1, 0, 16'h0, 4'h0, 4'h0); c(16, 0, 1, 1, 16'h1111, 4'h0, 4'h0);
    c(17, 0, 1, 0, 16'h1111, 4'h0, 4'h0); c(31, 3, 1, 0, 16'h1111, 4'h0, 4'h0);
    c(32, 0, 0, 1, 16'h2222, 4'h0, 4'h0); c(33, 0, 0, 0, 16'h2222, 4'h0, 4'h0);
    run("collision", 40, -1);
    w(3, 16'h5A5A, 4'h0, 4'b1001);
    c(16, 0, 0, 1, 16'h5A5A, 4'h0, 4'b0000); c(31, 3, 0, 0, 16'h5A5A, 4'h0, 4'b0000);
    c(32, 0, 0, 0, 16'h5A5A, 4'h0, 4'b1001); c(47, 3, 0, 0, 16'h5A5A, 4'h0, 4'b1001);
    c(48, 0, 0, 0, 16'h5A5A, 4'h0, 4'b1001); c(63, 3, 0, 0, 16'h5A5A, 4'h0, 4'b1001);
    c(64, 0, 0, 0, 16'h5A5A, 4'h0, 4'b0000); c(80, 0, 0, 0, 16'h5A5A, 4'h0, 4'b0000);
    c(96, 0, 0, 0, 16'h5A5A, 4'h0, 4'b1001);
    run("blink", 100, -1);
    w(2, 16'hCAFE, 4'b1111, 4'b1111);
    c(9, 2, 1, 0, 16'h0, 4'h0, 4'h0); c(11, 0, 0, 0, 16'h0, 4'h0, 4'h0);
    c(27, 0, 0, 0, 16'h0, 4'h0, 4'h0); c(28, 0, 0, 0, 16'h0, 4'h0, 4'h0);
    run("reset_mid", 45, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
